// File: rtl/plot_arbiter.sv
// Merges snake plots (FIFO-buffered), single food pixels and full-screen
// clears into one registered pixel-write stream for the VGA adapter.
module plot_arbiter #(
  parameter int         DEPTH        = 8,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000,
  parameter int         X_MAX        = 159,
  parameter int         Y_MAX        = 119
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] snake_x,
  input  logic [6:0] snake_y,
  input  logic [2:0] snake_colour,
  input  logic       snake_plot,
  input  logic [7:0] food_x,
  input  logic [6:0] food_y,
  input  logic [2:0] food_colour,
  input  logic       food_plot,
  input  logic       clear_req,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       clear_busy,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  state_e        state_q, state_d;
  pix_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  pix_t          food_q, food_d;
  logic          food_full_q, food_full_d;
  logic [7:0]    x_cnt_q, x_cnt_d;
  logic [6:0]    y_cnt_q, y_cnt_d;
  pix_t          out_q, out_d;
  logic          vga_plot_q, vga_plot_d;
  logic          clear_busy_q, clear_busy_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    food_d       = food_q;
    food_full_d  = food_full_q;
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    out_d        = out_q;
    vga_plot_d   = 1'b0;
    clear_busy_d = clear_busy_q;
    overflow_d   = overflow_q;
    push         = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          // Clear wins outright: pending snake/food pixels are discarded.
          state_d      = CLEAR;
          clear_busy_d = 1'b1;
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          cnt_d        = '0;
          food_full_d  = 1'b0;
          x_cnt_d      = '0;
          y_cnt_d      = '0;
        end else begin
          if (food_full_q) begin
            out_d       = food_q;
            vga_plot_d  = 1'b1;
            food_full_d = 1'b0;
          end else if (cnt_q != '0) begin
            pop        = 1'b1;
            out_d      = mem_q[rd_ptr_q];
            vga_plot_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + AW'(1);
          end
          if (food_plot) begin
            food_full_d = 1'b1;
            food_d      = '{x: food_x, y: food_y, c: food_colour};
          end
          if (snake_plot) begin
            if (cnt_q != (AW+1)'(DEPTH) || pop) push = 1'b1;
            else                                overflow_d = 1'b1;
          end
          if (push) wr_ptr_d = wr_ptr_q + AW'(1);
          if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
          else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
        end
      end
      CLEAR: begin
        out_d      = '{x: x_cnt_q, y: y_cnt_q, c: CLEAR_COLOUR};
        vga_plot_d = 1'b1;
        if (x_cnt_q == 8'(X_MAX)) begin
          x_cnt_d = '0;
          if (y_cnt_q == 7'(Y_MAX)) begin
            y_cnt_d      = '0;
            state_d      = IDLE;
            clear_busy_d = 1'b0;
          end else begin
            y_cnt_d = y_cnt_q + 7'd1;
          end
        end else begin
          x_cnt_d = x_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      food_q       <= '0;
      food_full_q  <= 1'b0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      out_q        <= '0;
      vga_plot_q   <= 1'b0;
      clear_busy_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      food_q       <= food_d;
      food_full_q  <= food_full_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      out_q        <= out_d;
      vga_plot_q   <= vga_plot_d;
      clear_busy_q <= clear_busy_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{x: snake_x, y: snake_y, c: snake_colour};
  end

  assign vga_x      = out_q.x;
  assign vga_y      = out_q.y;
  assign vga_colour = out_q.c;
  assign vga_plot   = vga_plot_q;
  assign clear_busy = clear_busy_q;
  assign overflow   = overflow_q;

endmodule
